mult_div_unit: RTL and testbench

//  Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV, DIVU, MTHI and MTLO.

---
 rtl/mult_div_unit.sv | 140 ++++++++++++++
 tb/tb_mult_div_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up in a final cycle before HI/LO are written.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    state_e               state_q;
    logic [CW-1:0]        count_q;
    logic                 is_div_q;
    logic                 neg_res_q;
    logic                 neg_rem_q;
    logic [WIDTH-1:0]     b_abs_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Unsigned ops never negate, so 0x80000000 passes through as its own magnitude.
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        a_abs = a_neg ? -a : a;
        b_abs = b_neg ? -b : b;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_abs_q} : '0);
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, b_abs_q};
        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
        if (is_div_q) begin
            if (!diff[WIDTH])
                acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_abs_q   <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        b_abs_q   <= b_abs;
                        acc_q     <= {{WIDTH{1'b0}}, a_abs};
                        count_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end else begin
                        if (mthi) hi_q <= a;
                        if (mtlo) lo_q <= a;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1))
                        state_q <= FIX;
                end
                FIX: begin
                    // Divide-by-zero: quotient is forced; the remainder path already yields raw a.
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= (b_abs_q == '0) ? '1 : quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: reference results come from native SV arithmetic.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, sp;
        logic [63:0] ux, uy;
        int ix, iy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        ix = $signed(x);
        iy = $signed(y);
        case (o)
            2'b00: begin sp = sx * sy; return sp; end
            2'b01: return ux * uy;
            2'b10: begin
                if (y == 32'h0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = ix / iy;
                r = ix % iy;
                return {r, q};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where done is first seen.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit disturb, output int lat);
        int busy_cnt;
        logic [63:0] exp;
        start = 1'b1; op = o; a = x; b = y;
        sb.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL accept busy=%b done=%b required busy=1 done=0", busy, done);
        end
        busy_cnt = 1;
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) busy_cnt++;
            if (disturb && lat == 5) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1; a = 32'hDEADBEEF; b = 32'h7; op = 2'b11;
            end
            if (disturb && lat == 6) begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            if (lat == 20) begin
                checks++;
                if (hi !== model_hi || lo !== model_lo) begin
                    errors++;
                    $display("FAIL hold_midop hi=%h lo=%h required hi=%h lo=%h", hi, lo, model_hi, model_lo);
                end
            end
        end
        exp = sb.pop_front();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout lat=%0d required done within 50 cycles", lat);
        end else begin
            checks++;
            if (lat != 33 || busy_cnt != 33 || busy !== 1'b0) begin
                errors++;
                $display("FAIL timing lat=%0d busy_cycles=%0d busy=%b required 33 33 0", lat, busy_cnt, busy);
            end
            checks++;
            if (hi !== exp[63:32] || lo !== exp[31:0]) begin
                errors++;
                $display("FAIL result op=%0d a=%h b=%h hi=%h lo=%h required hi=%h lo=%h",
                         o, x, y, hi, lo, exp[63:32], exp[31:0]);
            end
        end
        model_hi = exp[63:32];
        model_lo = exp[31:0];
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int lat;
        do_op(2'b00, 32'hFFFFFFFD, 32'h5, 1'b0, lat);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b required 0", done);
        end
    endtask

    task automatic test_multu();
        int lat;
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat);
        @(negedge clk);
    endtask

    task automatic test_div();
        int lat;
        do_op(2'b10, 32'hFFFFFFF9, 32'h2, 1'b0, lat);
        @(negedge clk);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat);
        @(negedge clk);
        do_op(2'b10, 32'h7, 32'hFFFFFFFE, 1'b0, lat);
        @(negedge clk);
    endtask

    task automatic test_divzero();
        int lat;
        do_op(2'b11, 32'h64, 32'h0, 1'b0, lat);
        @(negedge clk);
        do_op(2'b10, 32'hFFFFFFF9, 32'h0, 1'b0, lat);
        @(negedge clk);
    endtask

    task automatic test_held_inputs();
        int lat;
        do_op(2'b00, 32'h00012345, 32'hFFFF0003, 1'b1, lat);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_midop();
        bit seen_done;
        start = 1'b1; op = 2'b01; a = 32'hFFFF; b = 32'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_midop busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
        end
        model_hi = '0;
        model_lo = '0;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_discard activity=%b hi=%h lo=%h required 0 0 0", seen_done, hi, lo);
        end
    endtask

    task automatic test_mt();
        mthi = 1'b1; mtlo = 1'b1; a = 32'h1234;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        checks++;
        if (hi !== 32'h1234 || lo !== 32'h1234 || done !== 1'b0) begin
            errors++;
            $display("FAIL mt_both hi=%h lo=%h done=%b required 1234 1234 0", hi, lo, done);
        end
        mthi = 1'b1; a = 32'hBEEF;
        @(negedge clk);
        mthi = 1'b0;
        checks++;
        if (hi !== 32'hBEEF || lo !== 32'h1234) begin
            errors++;
            $display("FAIL mthi_only hi=%h lo=%h required 0000beef 00001234", hi, lo);
        end
        mtlo = 1'b1; a = 32'hAAAA5555;
        @(negedge clk);
        mtlo = 1'b0;
        checks++;
        if (hi !== 32'hBEEF || lo !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL mtlo_only hi=%h lo=%h required 0000beef aaaa5555", hi, lo);
        end
        model_hi = 32'hBEEF;
        model_lo = 32'hAAAA5555;
    endtask

    task automatic test_start_mt();
        int lat;
        mtlo = 1'b1;
        do_op(2'b01, 32'h10, 32'h10, 1'b0, lat);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [1:0]  ops[6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
        logic [31:0] as[6]  = '{32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h0000000D, 32'h7FFFFFFF};
        logic [31:0] bs[6]  = '{32'h80000000, 32'h2, 32'h00000003, 32'h00000010, 32'hFFFFFFFB, 32'hFFFFFFFF};
        for (int i = 0; i < 6; i++)
            do_op(ops[i], as[i], bs[i], 1'b0, lat);
        for (int i = 0; i < 6; i++)
            do_op(2'($urandom), $urandom, (i == 3) ? 32'h0 : $urandom, 1'b0, lat);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divzero();
        test_held_inputs();
        test_reset_midop();
        test_mt();
        test_start_mt();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
